// File: rtl/minmax_pkg.sv
// Shared types and constants for the min/max frame sequencer.
package minmax_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StWait,
      StOut
   } state_e;

   localparam int unsigned DATA_W_DEF  = 8;
   localparam int unsigned N_BYTES_DEF = 8;

   // Width needed to hold any count in 0..n inclusive.
   function automatic int unsigned cnt_w(input int unsigned n);
      return $clog2(n + 1);
   endfunction

   localparam int unsigned BYTE_CNT_W_DEF = cnt_w(N_BYTES_DEF);

endpackage

// File: rtl/minmax_frame_sequencer.sv
// Groups upstream bytes into frames, strobes them into the min/max datapath and
// hands the result (or a timeout error) downstream on a valid/ready port.
module minmax_frame_sequencer
   import minmax_pkg::*;
#(
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned N_BYTES = N_BYTES_DEF,
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CNT_W   = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              dp_start_o,
   output logic              dp_load_o,
   output logic [DATA_W-1:0] dp_data_o,
   input  logic              dp_done_i,
   input  logic [DATA_W-1:0] dp_w_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic              out_err_o,
   output logic              busy_o,
   output logic [CNT_W-1:0]  frame_cnt_o
);

   localparam int unsigned BCW = cnt_w(N_BYTES);
   localparam int unsigned TCW = cnt_w(TIMEOUT);
   localparam logic [BCW-1:0] LastByte    = BCW'(N_BYTES - 1);
   localparam logic [TCW-1:0] TimeoutLast = TCW'(TIMEOUT - 1);

   state_e            state_q;
   logic [BCW-1:0]    byte_cnt_q;
   logic [TCW-1:0]    to_cnt_q;
   logic              dp_start_q;
   logic              dp_load_q;
   logic [DATA_W-1:0] dp_data_q;
   logic              out_valid_q;
   logic [DATA_W-1:0] out_data_q;
   logic              out_err_q;
   logic [CNT_W-1:0]  frame_cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         byte_cnt_q  <= '0;
         to_cnt_q    <= '0;
         dp_start_q  <= 1'b0;
         dp_load_q   <= 1'b0;
         dp_data_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_err_q   <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         // Strobes are single-cycle unless re-armed below.
         dp_start_q <= 1'b0;
         dp_load_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (in_valid_i) begin
                  dp_start_q <= 1'b1;
                  dp_load_q  <= 1'b1;
                  dp_data_q  <= in_data_i;
                  byte_cnt_q <= BCW'(1);
                  state_q    <= StLoad;
               end
            end
            StLoad: begin
               if (in_valid_i) begin
                  dp_load_q  <= 1'b1;
                  dp_data_q  <= in_data_i;
                  byte_cnt_q <= byte_cnt_q + 1'b1;
                  if (byte_cnt_q == LastByte) begin
                     state_q <= StWait;
                  end
               end
            end
            StWait: begin
               to_cnt_q <= to_cnt_q + 1'b1;
               // A result arriving in the timeout cycle takes priority.
               if (dp_done_i) begin
                  out_data_q  <= dp_w_i;
                  out_err_q   <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= StOut;
               end else if (to_cnt_q == TimeoutLast) begin
                  out_data_q  <= '0;
                  out_err_q   <= 1'b1;
                  out_valid_q <= 1'b1;
                  state_q     <= StOut;
               end
            end
            StOut: begin
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  frame_cnt_q <= frame_cnt_q + 1'b1;
                  byte_cnt_q  <= '0;
                  to_cnt_q    <= '0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      in_ready_o = (state_q == StIdle) || (state_q == StLoad);
      busy_o     = (state_q != StIdle);
   end

   assign dp_start_o  = dp_start_q;
   assign dp_load_o   = dp_load_q;
   assign dp_data_o   = dp_data_q;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_err_o   = out_err_q;
   assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_minmax_frame_sequencer.sv
// Directed bench for minmax_frame_sequencer with a behavioural min/max datapath.
module tb_minmax_frame_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data = 8'd0;
   logic        dp_start;
   logic        dp_load;
   logic [7:0]  dp_data;
   logic        dp_done;
   logic [7:0]  dp_w;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  out_data;
   logic        out_err;
   logic        busy;
   logic [15:0] frame_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   minmax_frame_sequencer #(
      .DATA_W (8),
      .N_BYTES(8),
      .TIMEOUT(64),
      .CNT_W  (16)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .in_data_i  (in_data),
      .dp_start_o (dp_start),
      .dp_load_o  (dp_load),
      .dp_data_o  (dp_data),
      .dp_done_i  (dp_done),
      .dp_w_i     (dp_w),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .out_data_o (out_data),
      .out_err_o  (out_err),
      .busy_o     (busy),
      .frame_cnt_o(frame_cnt)
   );

   // Behavioural datapath: done in the same cycle the 8th load is presented.
   logic       dp_en = 1'b1;
   logic       force_done = 1'b0;
   logic [7:0] m_mn, m_mx, cur_mn, cur_mx;
   logic [3:0] m_cnt;

   always @(posedge clk) begin
      if (dp_load) begin
         m_mn  <= cur_mn;
         m_mx  <= cur_mx;
         m_cnt <= dp_start ? 4'd1 : m_cnt + 4'd1;
      end
   end

   always_comb begin
      cur_mn = dp_start ? dp_data : ((dp_data < m_mn) ? dp_data : m_mn);
      cur_mx = dp_start ? dp_data : ((dp_data > m_mx) ? dp_data : m_mx);
   end

   assign dp_w    = 8'((9'(cur_mn) + 9'(cur_mx)) >> 1);
   assign dp_done = force_done |
                    (dp_en & dp_load & (((dp_start ? 4'd0 : m_cnt) + 4'd1) == 4'd8));

   // Strobe monitor; gaps are dp_load=0 cycles while in LOAD (busy & in_ready).
   int n_start = 0;
   int n_load  = 0;
   int n_gap   = 0;
   always @(negedge clk) begin
      if (dp_start) n_start++;
      if (dp_load) n_load++;
      if (busy && in_ready && !dp_load) n_gap++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit done = 0;
      in_valid = 1'b1;
      in_data  = b;
      for (int k = 0; k < 200 && !done; k++) begin
         if (in_ready) done = 1;
         tick();
      end
      in_valid = 1'b0;
      if (!done) chk("send_byte_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_frame(input logic [63:0] bytes, input logic [7:0] gaps);
      for (int i = 0; i < 8; i++) begin
         send_byte(bytes[8*i +: 8]);
         if (gaps[i]) tick();
      end
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 300) begin
         tick();
         n++;
      end
      if (!out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
   endtask

   typedef struct {
      logic [63:0] bytes;  // byte 0 in bits [7:0]
      logic [7:0]  gaps;   // bit i: idle cycle after byte i
      logic [7:0]  exp;
      int          exp_gaps;
   } vec_t;

   vec_t tbl[5];

   initial begin
      int n;
      int s0, l0, g0;
      logic [7:0] held;
      bit stable;

      // 10,200,3,77,90,150,4,60 -> (3+200)/2 = 101
      tbl[0] = '{64'h3C04_965A_4D03_C80A, 8'h00, 8'd101, 0};
      tbl[1] = '{64'h3C04_965A_4D03_C80A, 8'h12, 8'd101, 2};
      tbl[2] = '{64'h3232_3232_3232_3232, 8'h00, 8'd50, 0};
      tbl[3] = '{64'h0505_0505_0505_FF00, 8'h40, 8'd127, 1};
      tbl[4] = '{64'h0807_0605_0403_0201, 8'h01, 8'd4, 1};

      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_dp_data", 32'(dp_data), 32'd0);
      chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("idle_in_ready", 32'(in_ready), 32'd1);

      for (int i = 0; i < 5; i++) begin
         s0 = n_start; l0 = n_load; g0 = n_gap;
         send_frame(tbl[i].bytes, tbl[i].gaps);
         if (tbl[i].gaps[7]) chk("frame_in_ready_low", 32'(in_ready), 32'd0);
         else                chk("frame_in_ready_low", 32'(in_ready), 32'd0);
         wait_valid(n);
         chk("frame_latency", 32'(n), tbl[i].gaps[7] ? 32'd0 : 32'd1);
         chk("frame_out_data", 32'(out_data), 32'(tbl[i].exp));
         chk("frame_out_err", 32'(out_err), 32'd0);
         tick();
         chk("frame_hs_valid", 32'(out_valid), 32'd0);
         chk("frame_hs_in_ready", 32'(in_ready), 32'd1);
         chk("frame_cnt", 32'(frame_cnt), 32'(i + 1));
         chk("frame_starts", 32'(n_start - s0), 32'd1);
         chk("frame_loads", 32'(n_load - l0), 32'd8);
         chk("frame_gaps", 32'(n_gap - g0), 32'(tbl[i].exp_gaps));
      end

      // Timeout: datapath silent, result after exactly TIMEOUT cycles in WAIT.
      dp_en = 1'b0;
      send_frame(tbl[0].bytes, 8'h00);
      wait_valid(n);
      chk("to_latency", 32'(n), 32'd64);
      chk("to_out_data", 32'(out_data), 32'd0);
      chk("to_out_err", 32'(out_err), 32'd1);
      tick();
      chk("to_frame_cnt", 32'(frame_cnt), 32'd6);
      chk("to_in_ready", 32'(in_ready), 32'd1);
      dp_en = 1'b1;

      // Downstream backpressure.
      out_ready = 1'b0;
      send_frame(tbl[0].bytes, 8'h00);
      wait_valid(n);
      held = out_data;
      stable = 1;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (!out_valid || out_data !== held || in_ready !== 1'b0) stable = 0;
      end
      chk("bp_held_data", 32'(held), 32'd101);
      chk("bp_stable", 32'(stable), 32'd1);
      out_ready = 1'b1;
      tick();
      chk("bp_hs_valid", 32'(out_valid), 32'd0);
      chk("bp_frame_cnt", 32'(frame_cnt), 32'd7);
      send_frame({8{8'hFF}}, 8'h00);
      wait_valid(n);
      chk("ff_out_data", 32'(out_data), 32'd255);
      tick();

      // dp_done pulses outside WAIT are ignored.
      force_done = 1'b1;
      tick();
      tick();
      force_done = 1'b0;
      chk("idle_done_ignored", 32'(out_valid), 32'd0);
      for (int i = 0; i < 3; i++) send_byte(tbl[0].bytes[8*i +: 8]);
      force_done = 1'b1;
      tick();
      force_done = 1'b0;
      chk("load_done_ignored", 32'(out_valid), 32'd0);
      chk("load_still_busy", 32'(busy & in_ready), 32'd1);
      for (int i = 3; i < 8; i++) send_byte(tbl[0].bytes[8*i +: 8]);
      wait_valid(n);
      chk("ign_out_data", 32'(out_data), 32'd101);
      tick();
      chk("ign_frame_cnt", 32'(frame_cnt), 32'd9);

      // Asynchronous reset mid-LOAD discards the partial frame.
      for (int i = 0; i < 4; i++) send_byte(8'd99);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_dp_load", 32'(dp_load), 32'd0);
      chk("mid_rst_dp_data", 32'(dp_data), 32'd0);
      chk("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      tick();
      rst_n = 1'b1;
      tick();
      send_frame(64'h0800_0000_0000_0000, 8'h00);
      wait_valid(n);
      chk("post_rst_out_data", 32'(out_data), 32'd4);
      chk("post_rst_err", 32'(out_err), 32'd0);
      tick();
      chk("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
